// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdc_pkg
// Brief    : Shared definitions for the req/ack CDC handshake transmitter and
//            receiver: FSM state encoding and default synchronizer depth.
// Revision : 1.0 - initial release
// ============================================================================
package cdc_pkg;

  // Handshake FSM state encoding (2-bit, explicit values)
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_state_t;

  // Default depth of the acknowledge/request synchronizer chains
  localparam int SYNC_FFS_DEFAULT = 2;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/sync.sv
`default_nettype none
// ============================================================================
// Module   : sync
// Brief    : NUM_FFS-deep flop-chain synchronizer for a single asynchronous
//            level signal. Output is the last flop of the chain.
// Revision : 1.0 - initial release
// ============================================================================
module sync #(
  parameter int NUM_FFS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_sig,
  output logic sync_sig
);

  logic [NUM_FFS-1:0] sync_ff;

  // Shift the asynchronous level through the chain; reset clears every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[NUM_FFS-2:0], async_sig};
    end
  end

  assign sync_sig = sync_ff[NUM_FFS-1];

endmodule : sync
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Brief    : Transmit side of a 4-phase req/ack clock-domain-crossing
//            handshake. Accepts a word over valid/ready, holds it on
//            xfer_data, raises req and completes return-to-zero using a
//            synchronized copy of ack. Pulses done when a transfer ends.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int NUM_FFS    = SYNC_FFS_DEFAULT,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  ack,
  output logic                  done
);

  hs_state_t state;
  hs_state_t state_nxt;
  logic      ack_s;
  logic      load;
  logic      req_nxt;
  logic      done_nxt;

  // ack is only ever used through this synchronizer
  sync #(
    .NUM_FFS   (NUM_FFS)
  ) u_ack_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_sig (ack),
    .sync_sig  (ack_s)
  );

  // A stale synchronized ack (e.g. after a reset mid-transfer) keeps the
  // block from accepting until the remote side has returned to zero.
  assign in_ready = (state == IDLE) && !ack_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept -> wait ack high -> wait ack low -> idle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load)   state_nxt = REQ;
      REQ:     if (ack_s)  state_nxt = RELEASE;
      RELEASE: if (!ack_s) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    load     = (state == IDLE) && in_valid && in_ready;
    req_nxt  = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE:    req_nxt  = load;
      REQ:     req_nxt  = !ack_s;
      RELEASE: done_nxt = !ack_s;
      default: req_nxt  = 1'b0;
    endcase
  end

  // Registered outputs keep req glitch-free; data changes only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req       <= 1'b0;
      done      <= 1'b0;
      xfer_data <= '0;
    end else begin
      req  <= req_nxt;
      done <= done_nxt;
      if (load) begin
        xfer_data <= in_data;
      end
    end
  end

endmodule : cdc_handshake_tx
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Brief    : Self-checking bench for cdc_handshake_tx. Instance A uses a
//            2-flop ack synchronizer with a req->ack echo responder and a
//            queue scoreboard; instance B uses a 3-flop synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

  localparam int DW    = 8;
  localparam int NFF_A = 2;
  localparam int NFF_B = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A signals
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [DW-1:0] a_data  = '0;
  logic          a_req;
  logic [DW-1:0] a_xfer;
  logic          a_ack   = 1'b0;
  logic          a_done;

  // instance B signals
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [DW-1:0] b_data  = '0;
  logic          b_req;
  logic [DW-1:0] b_xfer;
  logic          b_ack   = 1'b0;
  logic          b_done;

  cdc_handshake_tx #(.NUM_FFS(NFF_A), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .req(a_req), .xfer_data(a_xfer), .ack(a_ack), .done(a_done)
  );

  cdc_handshake_tx #(.NUM_FFS(NFF_B), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .req(b_req), .xfer_data(b_xfer), .ack(b_ack), .done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // edge counter: value equals the number of the most recent posedge
  always @(posedge clk) cyc++;

  // ---------------- responder A: ack = req delayed resp_lat cycles ---------
  logic       auto_ack = 1'b1;
  int         resp_lat = 1;
  logic [7:0] req_hist = '0;
  int         a_ack_rise_cyc = 0;
  int         a_ack_fall_cyc = 0;

  always @(posedge clk) begin
    #1;
    req_hist = {req_hist[6:0], a_req};
    if (auto_ack && (a_ack !== req_hist[resp_lat])) begin
      a_ack = req_hist[resp_lat];
      if (a_ack) a_ack_rise_cyc = cyc;
      else       a_ack_fall_cyc = cyc;
    end
  end

  // ---------------- responder B: fixed 1-cycle echo ------------------------
  logic [1:0] b_hist = '0;
  int         b_ack_rise_cyc = 0;
  int         b_ack_fall_cyc = 0;

  always @(posedge clk) begin
    #1;
    b_hist = {b_hist[0], b_req};
    if (b_ack !== b_hist[1]) begin
      b_ack = b_hist[1];
      if (b_ack) b_ack_rise_cyc = cyc;
      else       b_ack_fall_cyc = cyc;
    end
  end

  // ---------------- scoreboard / monitor for A -----------------------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_word  = '0;
  logic          mon_en    = 1'b0;
  logic          prev_req  = 1'b0;
  logic          prev_done = 1'b0;
  logic          exp_accept = 1'b0;
  int            sent_cnt  = 0;
  int            done_cnt  = 0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (exp_accept) begin
        check("accept_after_done", {31'd0, a_req}, 32'd1);
        exp_accept = 1'b0;
      end
      if (a_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
          cur_word = exp_q.pop_front();
        end
      end
      if (a_req) begin
        check("xfer_data_held", {24'd0, a_xfer}, {24'd0, cur_word});
        check("ready_low_busy", {31'd0, a_ready}, 32'd0);
      end
      if (!a_req && prev_req)
        check("req_fall_latency", cyc - a_ack_rise_cyc, NFF_A + 1);
      if (a_done) begin
        check("done_latency", cyc - a_ack_fall_cyc, NFF_A + 1);
        check("ready_with_done", {31'd0, a_ready}, 32'd1);
        if (a_valid) exp_accept = 1'b1;
      end
      if (prev_done)
        check("done_one_cycle", {31'd0, a_done}, 32'd0);
    end
    if (rst_n && a_done) done_cnt++;
    prev_req  = a_req;
    prev_done = a_done;
  end

  // Present a word on A and hold it until accepted
  task automatic send_a(input logic [DW-1:0] w);
    int t;
    exp_q.push_back(w);
    sent_cnt++;
    a_data  = w;
    a_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!a_ready && t < 200);
    if (!a_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("req_on_accept", {31'd0, a_req}, 32'd1);
    check("xfer_on_accept", {24'd0, a_xfer}, {24'd0, w});
    a_valid = 1'b0;
    a_data  = DW'($urandom);
  endtask

  // Wait until every word sent on A has completed
  task automatic drain_a();
    int t;
    t = 0;
    while (done_cnt < sent_cnt && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < sent_cnt) check("drain_timeout", done_cnt, sent_cnt);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int start_b;

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req",   {31'd0, a_req},   32'd0);
    check("rst_done",  {31'd0, a_done},  32'd0);
    check("rst_xfer",  {24'd0, a_xfer},  32'd0);
    check("rst_ready", {31'd0, a_ready}, 32'd1);
    check("rst_ready_b", {31'd0, b_ready}, 32'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // ---- single transfer ----
    resp_lat = 1;
    send_a(8'hA5);
    drain_a();

    // ---- back-to-back ----
    send_a(8'h01);
    send_a(8'h02);
    drain_a();

    // ---- input ignored while busy ----
    send_a(8'hA5);
    a_data  = 8'hFF;
    a_valid = 1'b1;
    @(negedge clk);
    check("busy_xfer_kept", {24'd0, a_xfer}, 32'hA5);
    check("busy_not_ready", {31'd0, a_ready}, 32'd0);
    t = 0;
    while (a_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    a_valid = 1'b0;
    check("busy_xfer_after", {24'd0, a_xfer}, 32'hA5);
    drain_a();

    // ---- randomized batches with varying responder latency ----
    for (int lat = 1; lat <= 3; lat++) begin
      resp_lat = lat;
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send_a(DW'($urandom));
      end
      drain_a();
    end
    resp_lat = 1;

    // ---- reset mid-transfer with ack stuck high ----
    send_a(8'h3C);
    t = 0;
    while (!a_ack && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_in_req", {31'd0, a_req}, 32'd1);
    auto_ack = 1'b0;
    mon_en   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req",  {31'd0, a_req},  32'd0);
    check("async_rst_xfer", {24'd0, a_xfer}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NFF_A + 1) @(posedge clk);
    @(negedge clk);
    check("stale_ack_blocks", {31'd0, a_ready}, 32'd0);
    @(posedge clk);
    #1 a_ack = 1'b0;
    @(negedge clk);
    check("stale_ready_1", {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    check("stale_ready_2", {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    check("stale_ready_release", {31'd0, a_ready}, 32'd1);
    check("stale_no_req", {31'd0, a_req}, 32'd0);
    done_cnt = sent_cnt;
    repeat (5) @(posedge clk);
    #1;
    auto_ack = 1'b1;
    mon_en   = 1'b1;
    send_a(8'h5A);
    drain_a();

    // ---- NUM_FFS = 3 single transfer on instance B ----
    b_data  = 8'hA5;
    b_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!b_ready && t < 50);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    check("b_req_on_accept", {31'd0, b_req}, 32'd1);
    check("b_xfer", {24'd0, b_xfer}, 32'hA5);
    start_b = cyc;
    t = 0;
    while (b_req && t < 100) begin
      @(negedge clk);
      if (b_req) check("b_xfer_held", {24'd0, b_xfer}, 32'hA5);
      t++;
    end
    check("b_req_fall_latency", cyc - b_ack_rise_cyc, NFF_B + 1);
    t = 0;
    while (!b_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b_done_seen", {31'd0, b_done}, 32'd1);
    check("b_done_latency", cyc - b_ack_fall_cyc, NFF_B + 1);
    check("b_round_trip", cyc - start_b, 2 * (1 + NFF_B) + 2);
    @(negedge clk);
    check("b_done_width", {31'd0, b_done}, 32'd0);

    // ---- final bookkeeping ----
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("done_count", done_cnt, sent_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_cdc_handshake_tx
`default_nettype wire

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side (transmitter) end of a 4-phase req/ack clock-domain-crossing handshake. Accepts a data word from local `clk`-domain logic over a valid/ready interface and holds it stable on `xfer_data`. Raises `req` toward the remote domain and completes the return-to-zero protocol using an internally synchronized copy of the asynchronous `ack`. It pairs with the existing `sync` block, which the remote receiver uses on `req`.

## Interface
- `NUM_FFS`, 2: synchronizer depth for `ack`; legal range ≥ 2.
- `DATA_WIDTH`, 8: width of the transferred word.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset; asynchronous, active-low. One clock; this polarity and synchronicity are fixed.
- `in_valid`  input  1  upstream word valid.
- `in_ready`  output  1  block can accept a word.
- `in_data`  input  DATA_WIDTH  upstream word.
- `req`  output  1  handshake request toward the remote domain; registered, glitch-free.
- `xfer_data`  output  DATA_WIDTH  held word; stable whenever `req` = 1.
- `ack`  input  1  asynchronous acknowledge from the remote domain.
- `done`  output  1  one-cycle pulse when a transfer fully completes.

## Operation
- FSM states: IDLE, REQ, RELEASE.
- `ack_s` is `ack` passed through an `NUM_FFS`-deep flop chain. It resets to 0.
- **IDLE**
  - `in_ready` = (state == IDLE) && !`ack_s`. This is combinational from registers only, with no path from `in_valid`.
  - On `in_valid && in_ready`: capture `in_data` into `xfer_data`, set `req` ← 1, go to REQ.
- **REQ**
  - `req` is held at 1 and `xfer_data` is held.
  - When `ack_s` == 1: set `req` ← 0 and go to RELEASE.
- **RELEASE**
  - `req` is held at 0.
  - When `ack_s` == 0: go to IDLE and set `done` ← 1 for exactly one cycle.
- `xfer_data` changes only on an accept edge; it is never altered in REQ or RELEASE.
- `in_data` and `in_valid` are ignored outside IDLE.
- A stale `ack_s` = 1 in IDLE (for example, after a reset mid-transfer) blocks acceptance until `ack_s` returns to 0.
- **Reset mid-operation:** all of the following clear immediately and asynchronously:
  - `req` = 0, `done` = 0, `xfer_data` = 0, `ack_s` chain = 0, state = IDLE.
  - The in-flight word is dropped.
- **Reset values:** `req` = 0, `done` = 0, `xfer_data` = 0, `in_ready` = 1 (IDLE, `ack_s` = 0).

## Timing
- Accept at posedge N: `req` and `xfer_data` are valid after edge N.
- `ack` rising is seen as `ack_s` = 1 after `NUM_FFS` posedges. `req` falls on the following edge.
- `ack` falling is likewise seen after `NUM_FFS` edges. The FSM enters IDLE and `done` = 1 on that same edge, and `done` clears on the next edge.
- `in_ready` is high in the same cycle `done` is high, so a new word can be accepted on the edge immediately after the `done` edge.
- **Minimum round trip:** if the remote side echoes `req` as `ack` with latency R cycles, one transfer takes roughly 2·(R + `NUM_FFS`) + 2 cycles.
- **Simultaneous events:** an `ack` edge arriving on the same edge as a state change only takes effect through `ack_s`, so there is no combinational `ack` use.

## Structure
- **Shared package `cdc_pkg`:** holds the FSM state typedef (IDLE = 2'd0, REQ = 2'd1, RELEASE = 2'd2) and the default `NUM_FFS` constant. The receiver side uses the same package.
- **Sub-module:** instantiate the existing `sync` block (`NUM_FFS` parameter, ports `clk`/`rst_n`/`async_sig`/`sync_sig`) for `ack`. Write no inline synchronizer.
- Remaining logic is a single FSM `always` block plus the data register.

## Test plan
1. **Reset state.** Hold `rst_n` = 0 for 3 cycles, then release. Require `req` = 0, `done` = 0, `xfer_data` = 0, `in_ready` = 1.
2. **Single transfer** (`NUM_FFS` = 2, responder echoes `req` as `ack` after 1 cycle).
   - Stimulus: `in_data` = 8'hA5 with `in_valid` for one cycle.
   - Required response: `req` rises on the accept edge, `xfer_data` = 8'hA5 throughout `req` = 1, `req` falls 3 edges after `ack` rises, and `done` pulses once.
3. **Back-to-back.** Hold `in_valid` with 8'h01 then 8'h02.
   - The second word must be accepted on the edge right after `done`.
   - `xfer_data` must not change while `req` = 1.
4. **Input ignored while busy.** Change `in_data` to 8'hFF during REQ with `in_valid` = 1. Require `xfer_data` to stay 8'hA5 and `in_ready` = 0.
5. **Reset mid-transfer.**
   - Assert `rst_n` = 0 while in REQ with `ack` = 1. Require `req` = 0 immediately.
   - After release with `ack` still 1: `in_ready` stays 0 until 2 cycles after `ack` drops.
6. **`NUM_FFS` = 3 rerun of scenario 2.** Require `req` to fall 4 edges after `ack` rises.
